// File: rtl/fetch_queue.sv
// fetch_queue: small FIFO that sits between instruction fetch and decode.
// Each entry holds one {instruction, PC} pair. The head entry is presented
// straight from storage, so decode sees a valid head one cycle after the
// fetch-side write. A flush empties the queue in one cycle without touching
// the storage array.
module fetch_queue #(
    parameter int DW_INSTR = 32,
    parameter int DW_PC    = 64,
    parameter int DP       = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DW_INSTR-1:0]   instr_readout,
    input  logic [DW_PC-1:0]      pc_in,
    input  logic                  isInstrReadOut,
    output logic                  fetch_ready,
    input  logic                  flush,
    output logic [DW_INSTR-1:0]   instr,
    output logic [DW_PC-1:0]      pc_out,
    output logic                  fetch_decode_vaild,
    input  logic                  instrFifo_full,
    output logic [$clog2(DP):0]   fetch_count
);

    // AW index bits plus one wrap bit; pointers count modulo 2*DP.
    localparam int AW = $clog2(DP);
    localparam int PW = AW + 1;

    typedef logic [PW-1:0] ptr_t;

    // Storage is deliberately not reset; only the pointers define contents.
    logic [DW_INSTR-1:0] instr_mem_q [DP];
    logic [DW_PC-1:0]    pc_mem_q    [DP];

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;

    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          empty;
    logic          full;
    logic          wr_en;
    logic          rd_en;

    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];

    // Equal pointers mean empty; same index with opposite wrap bits means full.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Handshakes:
    //   upstream   - a word transfers on a cycle where isInstrReadOut and
    //                fetch_ready are both high; fetch_ready depends only on the
    //                current occupancy, so a full queue refuses a write even if
    //                the head leaves in the same cycle.
    //   downstream - the head transfers on a cycle where fetch_decode_vaild is
    //                high and instrFifo_full is low; while instrFifo_full is
    //                high the head and its data hold steady.
    //   flush overrides both handshakes: nothing is written or read that cycle.
    assign wr_en = isInstrReadOut & ~full & ~flush;
    assign rd_en = ~empty & ~instrFifo_full & ~flush;

    // Outputs come only from registered pointers and storage.
    assign fetch_ready        = ~full;
    assign fetch_decode_vaild = ~empty;
    assign fetch_count        = wr_ptr_q - rd_ptr_q;
    assign instr              = instr_mem_q[rd_idx];
    assign pc_out             = pc_mem_q[rd_idx];

    // Next-pointer logic: advance on accepted transfers, zero both on flush.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    // Pointer registers; reset wins over flush and every handshake.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write at the write index; inputs are ignored during reset.
    always_ff @(posedge CLK) begin
        if (!RST && wr_en) begin
            instr_mem_q[wr_idx] <= instr_readout;
            pc_mem_q[wr_idx]    <= pc_in;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vector table for the documented corner cases, a
// 20-entry wrap-around stream, then randomized traffic checked against a
// queue-based model of the fetch queue.
module tb_fetch_queue;

  localparam int DW_INSTR = 32;
  localparam int DW_PC    = 64;
  localparam int DP       = 4;
  localparam int CW       = $clog2(DP) + 1;

  // ---------------- clock / reset / DUT ----------------
  logic                CLK = 1'b0;
  logic                RST = 1'b1;
  logic [DW_INSTR-1:0] instr_readout = '0;
  logic [DW_PC-1:0]    pc_in = '0;
  logic                isInstrReadOut = 1'b0;
  logic                fetch_ready;
  logic                flush = 1'b0;
  logic [DW_INSTR-1:0] instr;
  logic [DW_PC-1:0]    pc_out;
  logic                fetch_decode_vaild;
  logic                instrFifo_full = 1'b0;
  logic [CW-1:0]       fetch_count;

  always #5 CLK = ~CLK;

  fetch_queue #(.DW_INSTR(DW_INSTR), .DW_PC(DW_PC), .DP(DP)) dut (
    .CLK                (CLK),
    .RST                (RST),
    .instr_readout      (instr_readout),
    .pc_in              (pc_in),
    .isInstrReadOut     (isInstrReadOut),
    .fetch_ready        (fetch_ready),
    .flush              (flush),
    .instr              (instr),
    .pc_out             (pc_out),
    .fetch_decode_vaild (fetch_decode_vaild),
    .instrFifo_full     (instrFifo_full),
    .fetch_count        (fetch_count)
  );

  // ---------------- counters ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction word tied to its PC so every entry is self-identifying;
  // PC 0x80000000 maps to 0x00000013 (nop).
  function automatic logic [31:0] ins_of(input logic [63:0] p);
    return p[31:0] ^ 32'h8000_0013;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst, input logic fl, input logic wv,
                       input logic [31:0] ins, input logic [63:0] pc, input logic dsf);
    RST            = rst;
    flush          = fl;
    isInstrReadOut = wv;
    instr_readout  = ins;
    pc_in          = pc;
    instrFifo_full = dsf;
  endtask

  // One clock edge; outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          rst;
    logic          fl;
    logic          wv;
    logic [63:0]   pc;
    logic          dsf;
    logic          ev;      // expected outputs after the edge
    logic          er;
    logic [CW-1:0] ec;
    logic [63:0]   epc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic fl, input logic wv, input logic [63:0] pc,
                     input logic dsf, input logic ev, input logic er, input int ec,
                     input logic [63:0] epc);
    vec_t v;
    v.rst = rst; v.fl = fl; v.wv = wv; v.pc = pc; v.dsf = dsf;
    v.ev = ev; v.er = er; v.ec = CW'(ec); v.epc = epc;
    vecs.push_back(v);
  endtask

  // ---------------- scoreboard for random phase ----------------
  logic [DW_INSTR+DW_PC-1:0] exp_q[$];

  task automatic check_model();
    chk("rnd_valid", 64'(fetch_decode_vaild), 64'(exp_q.size() > 0));
    chk("rnd_ready", 64'(fetch_ready), 64'(exp_q.size() < DP));
    chk("rnd_count", 64'(fetch_count), 64'(exp_q.size()));
    if (exp_q.size() > 0) begin
      chk("rnd_instr", 64'(instr), 64'(exp_q[0][DW_INSTR+DW_PC-1:DW_PC]));
      chk("rnd_pc", pc_out, exp_q[0][DW_PC-1:0]);
    end
  endtask

  // Model update from the inputs applied for the coming edge.
  task automatic model_step(input logic rst, input logic fl, input logic wv,
                            input logic [31:0] ins, input logic [63:0] pc, input logic dsf);
    bit can_wr;
    bit do_rd;
    if (rst || fl) begin
      exp_q.delete();
    end else begin
      can_wr = (exp_q.size() < DP) && wv;
      do_rd  = (exp_q.size() > 0) && !dsf;
      if (do_rd) void'(exp_q.pop_front());
      if (can_wr) exp_q.push_back({ins, pc});
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // reset and first-cycle write
    add(1, 0, 0, 64'h0,         0, 0, 1, 0, 64'h0);
    add(1, 0, 1, 64'h1234,      0, 0, 1, 0, 64'h0);
    // single pass-through
    add(0, 0, 1, 64'h8000_0000, 0, 1, 1, 1, 64'h8000_0000);
    add(0, 0, 0, 64'h0,         0, 0, 1, 0, 64'h0);
    // fill and stall, fifth write ignored, then drain in order
    add(0, 0, 1, 64'h0,         1, 1, 1, 1, 64'h0);
    add(0, 0, 1, 64'h4,         1, 1, 1, 2, 64'h0);
    add(0, 0, 1, 64'h8,         1, 1, 1, 3, 64'h0);
    add(0, 0, 1, 64'hC,         1, 1, 0, 4, 64'h0);
    add(0, 0, 1, 64'h10,        1, 1, 0, 4, 64'h0);
    add(0, 0, 0, 64'h0,         0, 1, 1, 3, 64'h4);
    add(0, 0, 0, 64'h0,         0, 1, 1, 2, 64'h8);
    add(0, 0, 0, 64'h0,         0, 1, 1, 1, 64'hC);
    add(0, 0, 0, 64'h0,         0, 0, 1, 0, 64'h0);
    // full with simultaneous read and write: write refused
    add(0, 0, 1, 64'h20,        1, 1, 1, 1, 64'h20);
    add(0, 0, 1, 64'h24,        1, 1, 1, 2, 64'h20);
    add(0, 0, 1, 64'h28,        1, 1, 1, 3, 64'h20);
    add(0, 0, 1, 64'h2C,        1, 1, 0, 4, 64'h20);
    add(0, 0, 1, 64'h30,        0, 1, 1, 3, 64'h24);
    add(0, 0, 0, 64'h0,         0, 1, 1, 2, 64'h28);
    add(0, 0, 0, 64'h0,         0, 1, 1, 1, 64'h2C);
    add(0, 0, 0, 64'h0,         0, 0, 1, 0, 64'h0);
    // flush with a concurrent write
    add(0, 0, 1, 64'h40,        1, 1, 1, 1, 64'h40);
    add(0, 0, 1, 64'h44,        1, 1, 1, 2, 64'h40);
    add(0, 0, 1, 64'h48,        1, 1, 1, 3, 64'h40);
    add(0, 1, 1, 64'h100,       0, 0, 1, 0, 64'h0);
    add(0, 0, 1, 64'h104,       1, 1, 1, 1, 64'h104);
    add(0, 0, 0, 64'h0,         0, 0, 1, 0, 64'h0);
    // reset mid-stream
    add(0, 0, 1, 64'h200,       1, 1, 1, 1, 64'h200);
    add(0, 0, 1, 64'h204,       1, 1, 1, 2, 64'h200);
    add(1, 0, 1, 64'h208,       0, 0, 1, 0, 64'h0);
    add(0, 0, 1, 64'h300,       1, 1, 1, 1, 64'h300);
    add(0, 0, 0, 64'h0,         0, 0, 1, 0, 64'h0);
    // simultaneous read and write at occupancy 1; read while empty
    add(0, 0, 1, 64'h400,       1, 1, 1, 1, 64'h400);
    add(0, 0, 1, 64'h404,       0, 1, 1, 1, 64'h404);
    add(0, 0, 0, 64'h0,         0, 0, 1, 0, 64'h0);
    add(0, 0, 0, 64'h0,         0, 0, 1, 0, 64'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].wv, ins_of(vecs[i].pc), vecs[i].pc, vecs[i].dsf);
      tick();
      chk($sformatf("v%0d_valid", i), 64'(fetch_decode_vaild), 64'(vecs[i].ev));
      chk($sformatf("v%0d_ready", i), 64'(fetch_ready), 64'(vecs[i].er));
      chk($sformatf("v%0d_count", i), 64'(fetch_count), 64'(vecs[i].ec));
      if (vecs[i].ev) begin
        chk($sformatf("v%0d_pc", i), pc_out, vecs[i].epc);
        chk($sformatf("v%0d_instr", i), 64'(instr), 64'(ins_of(vecs[i].epc)));
      end
    end

    // wrap-around stream: 20 PCs, continuous read and write
    for (int k = 0; k < 20; k++) begin
      logic [63:0] p;
      p = 64'h1000 + 64'(k * 4);
      drive(0, 0, 1, ins_of(p), p, 0);
      tick();
      chk($sformatf("wrap%0d_count", k), 64'(fetch_count), 64'd1);
      chk($sformatf("wrap%0d_pc", k), pc_out, p);
      chk($sformatf("wrap%0d_instr", k), 64'(instr), 64'(ins_of(p)));
    end
    drive(0, 0, 0, '0, '0, 0);
    tick();
    chk("wrap_drain_valid", 64'(fetch_decode_vaild), 64'd0);

    // randomized traffic against the queue model
    drive(1, 0, 0, '0, '0, 0);
    tick();
    exp_q.delete();
    for (int c = 0; c < 3000; c++) begin
      logic        r_rst, r_fl, r_wv, r_dsf;
      logic [31:0] r_ins;
      logic [63:0] r_pc;
      check_model();
      r_rst = ($urandom_range(0, 99) == 0);
      r_fl  = ($urandom_range(0, 19) == 0);
      r_wv  = ($urandom_range(0, 9) < 7);
      r_dsf = ($urandom_range(0, 9) < 4);
      r_ins = $urandom;
      r_pc  = {$urandom, $urandom};
      drive(r_rst, r_fl, r_wv, r_ins, r_pc, r_dsf);
      model_step(r_rst, r_fl, r_wv, r_ins, r_pc, r_dsf);
      tick();
    end
    check_model();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
